// File: rtl/vdp_sprite_line_drawer.sv
// Sprite line drawer: loads up to NUM_SPR prepared sprite entries at line start, then emits one
// prioritised, CC-merged sprite pixel per dot and reports the first sprite collision of the line.
module vdp_sprite_line_drawer #(
  parameter int unsigned NUM_SPR   = 8,
  parameter int unsigned LINE_DOTS = 256
) (
  input  logic        CLK21M,
  input  logic        RESET,
  input  logic        LINE_START,
  input  logic [3:0]  SP_COUNT,
  input  logic        MAG,
  input  logic        DRAW_START,
  input  logic        DOT_EN,
  output logic [2:0]  RAM_ADDR,
  input  logic [31:0] RAM_Q,
  output logic [3:0]  PIX_COLOR,
  output logic        PIX_VALID,
  output logic        COL_HIT,
  output logic [8:0]  COL_X,
  output logic        BUSY
);

  localparam logic [3:0] MaxCount = 4'(NUM_SPR);
  localparam logic [8:0] LastDot  = 9'(LINE_DOTS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StReady, StDraw} state_e;

  state_e     state_q, state_d;
  logic [2:0] ram_addr_q, ram_addr_d;
  logic [3:0] count_q, count_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic [3:0] count_clamp;
  logic [2:0] cap_idx;
  logic [8:0] dot_q, dot_d;
  logic [8:0] col_x_q, col_x_d;
  logic       seen_q, seen_d;
  logic       col_hit_q, col_hit_d;
  logic       pix_valid_q, pix_valid_d;
  logic [3:0] pix_color_q, pix_color_d;

  logic        slot_vld_q [NUM_SPR];
  logic        slot_vld_d [NUM_SPR];
  logic [8:0]  slot_x_q   [NUM_SPR];
  logic [8:0]  slot_x_d   [NUM_SPR];
  logic [15:0] slot_pat_q [NUM_SPR];
  logic [15:0] slot_pat_d [NUM_SPR];
  logic [3:0]  slot_col_q [NUM_SPR];
  logic [3:0]  slot_col_d [NUM_SPR];
  logic        slot_cc_q  [NUM_SPR];
  logic        slot_cc_d  [NUM_SPR];
  logic        slot_ic_q  [NUM_SPR];
  logic        slot_ic_d  [NUM_SPR];
  logic        slot_ph_q  [NUM_SPR];
  logic        slot_ph_d  [NUM_SPR];

  logic        slot_act   [NUM_SPR];
  logic        slot_opq   [NUM_SPR];
  logic [9:0]  span;
  logic        base_found;
  logic        cand_seen;
  logic        collide;
  logic [3:0]  mix_color;
  logic        mix_valid;
  logic        unused_ram_msb;

  assign unused_ram_msb = RAM_Q[31];
  assign count_clamp    = (SP_COUNT > MaxCount) ? MaxCount : SP_COUNT;
  assign cap_idx        = 3'(fcnt_q - 4'd1);

  // Width compare is 10-bit so a sprite near the right edge never wraps back to dot 0.
  always_comb begin
    span = MAG ? 10'd32 : 10'd16;
    for (int i = 0; i < NUM_SPR; i++) begin
      slot_act[i] = slot_vld_q[i] && (dot_q >= slot_x_q[i]) &&
                    ({1'b0, dot_q} < ({1'b0, slot_x_q[i]} + span));
      slot_opq[i] = slot_act[i] && slot_pat_q[i][15];
    end
  end

  // Lowest-index opaque cc=0 slot is the base; later opaque cc=1 slots OR into it.
  always_comb begin
    base_found = 1'b0;
    cand_seen  = 1'b0;
    collide    = 1'b0;
    mix_color  = 4'h0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (slot_opq[i]) begin
        if (!slot_cc_q[i]) begin
          if (!base_found) begin
            base_found = 1'b1;
            mix_color  = slot_col_q[i];
          end
          if (!slot_ic_q[i]) begin
            if (cand_seen) collide = 1'b1;
            cand_seen = 1'b1;
          end
        end else if (base_found) begin
          mix_color = mix_color | slot_col_q[i];
        end
      end
    end
    mix_valid = base_found && (mix_color != 4'h0);
  end

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    count_d     = count_q;
    fcnt_d      = fcnt_q;
    dot_d       = dot_q;
    col_x_d     = col_x_q;
    seen_d      = seen_q;
    col_hit_d   = 1'b0;
    pix_valid_d = pix_valid_q;
    pix_color_d = pix_color_q;
    for (int i = 0; i < NUM_SPR; i++) begin
      slot_vld_d[i] = slot_vld_q[i];
      slot_x_d[i]   = slot_x_q[i];
      slot_pat_d[i] = slot_pat_q[i];
      slot_col_d[i] = slot_col_q[i];
      slot_cc_d[i]  = slot_cc_q[i];
      slot_ic_d[i]  = slot_ic_q[i];
      slot_ph_d[i]  = slot_ph_q[i];
    end
    if (state_q != StDraw) begin
      pix_valid_d = 1'b0;
      pix_color_d = 4'h0;
    end

    if (LINE_START) begin
      for (int i = 0; i < NUM_SPR; i++) slot_vld_d[i] = 1'b0;
      ram_addr_d  = 3'd0;
      fcnt_d      = 4'd0;
      count_d     = count_clamp;
      col_x_d     = 9'd0;
      seen_d      = 1'b0;
      pix_valid_d = 1'b0;
      pix_color_d = 4'h0;
      state_d     = (count_clamp == 4'd0) ? StReady : StFetch;
    end else begin
      case (state_q)
        StIdle: ;
        StFetch: begin
          ram_addr_d = ram_addr_q + 3'd1;
          fcnt_d     = fcnt_q + 4'd1;
          // Read data for address k lands one cycle later, so slot k is written in cycle k+1.
          if (fcnt_q != 4'd0) begin
            for (int i = 0; i < NUM_SPR; i++) begin
              if (cap_idx == 3'(i)) begin
                slot_vld_d[i] = 1'b1;
                slot_x_d[i]   = RAM_Q[8:0];
                slot_pat_d[i] = RAM_Q[24:9];
                slot_col_d[i] = RAM_Q[28:25];
                slot_cc_d[i]  = RAM_Q[29];
                slot_ic_d[i]  = RAM_Q[30];
                slot_ph_d[i]  = 1'b0;
              end
            end
          end
          if (fcnt_q == count_q) state_d = StReady;
        end
        StReady: begin
          if (DRAW_START) begin
            state_d = StDraw;
            dot_d   = 9'd0;
          end
        end
        StDraw: begin
          if (DOT_EN) begin
            pix_valid_d = mix_valid;
            pix_color_d = mix_color;
            if (collide && !seen_q) begin
              col_hit_d = 1'b1;
              col_x_d   = dot_q;
              seen_d    = 1'b1;
            end
            for (int i = 0; i < NUM_SPR; i++) begin
              if (slot_act[i]) begin
                slot_ph_d[i] = ~slot_ph_q[i];
                if (!MAG || slot_ph_q[i]) slot_pat_d[i] = {slot_pat_q[i][14:0], 1'b0};
              end
            end
            dot_d = dot_q + 9'd1;
            if (dot_q == LastDot) state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      state_q     <= StIdle;
      ram_addr_q  <= 3'd0;
      count_q     <= 4'd0;
      fcnt_q      <= 4'd0;
      dot_q       <= 9'd0;
      col_x_q     <= 9'd0;
      seen_q      <= 1'b0;
      col_hit_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_color_q <= 4'h0;
      for (int i = 0; i < NUM_SPR; i++) begin
        slot_vld_q[i] <= 1'b0;
        slot_x_q[i]   <= 9'd0;
        slot_pat_q[i] <= 16'h0;
        slot_col_q[i] <= 4'h0;
        slot_cc_q[i]  <= 1'b0;
        slot_ic_q[i]  <= 1'b0;
        slot_ph_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      count_q     <= count_d;
      fcnt_q      <= fcnt_d;
      dot_q       <= dot_d;
      col_x_q     <= col_x_d;
      seen_q      <= seen_d;
      col_hit_q   <= col_hit_d;
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
      for (int i = 0; i < NUM_SPR; i++) begin
        slot_vld_q[i] <= slot_vld_d[i];
        slot_x_q[i]   <= slot_x_d[i];
        slot_pat_q[i] <= slot_pat_d[i];
        slot_col_q[i] <= slot_col_d[i];
        slot_cc_q[i]  <= slot_cc_d[i];
        slot_ic_q[i]  <= slot_ic_d[i];
        slot_ph_q[i]  <= slot_ph_d[i];
      end
    end
  end

  assign RAM_ADDR  = ram_addr_q;
  assign PIX_COLOR = pix_color_q;
  assign PIX_VALID = pix_valid_q;
  assign COL_HIT   = col_hit_q;
  assign COL_X     = col_x_q;
  assign BUSY      = (state_q == StFetch) || (state_q == StDraw);

endmodule

// File: tb/tb_vdp_sprite_line_drawer.sv
// Bench for vdp_sprite_line_drawer: randomized lines checked every cycle against a per-dot
// arithmetic model of the sprite table, plus hand-computed directed expectations.
module tb_vdp_sprite_line_drawer;

  logic        clk = 1'b0;
  logic        rst, line_start, mag, draw_start, dot_en;
  logic [3:0]  sp_count;
  logic [2:0]  ram_addr;
  logic [31:0] ram_q;
  logic [3:0]  pix_color;
  logic        pix_valid, col_hit, busy;
  logic [8:0]  col_x;

  always #5 clk = ~clk;

  vdp_sprite_line_drawer #(.NUM_SPR(8), .LINE_DOTS(256)) dut (
    .CLK21M     (clk),
    .RESET      (rst),
    .LINE_START (line_start),
    .SP_COUNT   (sp_count),
    .MAG        (mag),
    .DRAW_START (draw_start),
    .DOT_EN     (dot_en),
    .RAM_ADDR   (ram_addr),
    .RAM_Q      (ram_q),
    .PIX_COLOR  (pix_color),
    .PIX_VALID  (pix_valid),
    .COL_HIT    (col_hit),
    .COL_X      (col_x),
    .BUSY       (busy)
  );

  logic [31:0] mem [8];
  always @(posedge clk) ram_q <= mem[ram_addr];

  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic        exp_busy, exp_valid, exp_hit;
  logic [3:0]  exp_color;
  logic [8:0]  exp_colx;
  logic [31:0] line_tab [8];
  int          line_cnt;
  bit          line_seen;
  int          fetch_cyc;
  int          hit_total;
  int          hit_base;
  bit          dut_vis [256];
  logic [3:0]  dut_col [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int x, input logic [15:0] pat, input logic [3:0] col,
                                     input bit cc, input bit ic);
    logic [8:0] xv;
    xv = 9'(x);
    return {1'b0, ic, cc, col, pat, xv};
  endfunction

  // Pixel for dot d straight from the table: offset into the pattern, no shift registers.
  function automatic void model_dot(input int d, input bit m, output bit v,
                                    output logic [3:0] c, output bit coll);
    bit opq [8];
    int base;
    int ncol;
    base = -1;
    ncol = 0;
    c    = 4'h0;
    for (int i = 0; i < 8; i++) opq[i] = 1'b0;
    for (int i = 0; i < line_cnt; i++) begin
      int x;
      int w;
      int off;
      x = int'(line_tab[i][8:0]);
      w = m ? 32 : 16;
      if (x < 256 && d >= x && d < x + w) begin
        off    = (d - x) >> m;
        opq[i] = line_tab[i][24 - off];
      end
    end
    for (int i = 0; i < 8; i++)
      if (base < 0 && opq[i] && !line_tab[i][29]) base = i;
    if (base >= 0) begin
      c = line_tab[base][28:25];
      for (int i = base + 1; i < 8; i++)
        if (opq[i] && line_tab[i][29]) c = c | line_tab[i][28:25];
    end
    for (int i = 0; i < 8; i++)
      if (opq[i] && !line_tab[i][29] && !line_tab[i][30]) ncol++;
    v    = (base >= 0) && (c != 4'h0);
    coll = (ncol >= 2);
  endfunction

  function automatic int vis_count();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) if (dut_vis[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] rand_entry(input int xbase);
    int         x;
    logic [31:0] e;
    x = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) : xbase + int'($urandom_range(0, 40));
    e = mk(x, 16'($urandom()), 4'($urandom()), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 3) == 0));
    e[31] = 1'($urandom());
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    exp_hit = 1'b0;
  endtask

  task automatic do_line_start(input int cnt, input bit ds_in_fetch);
    int ec;
    ec = (cnt > 8) ? 8 : cnt;
    for (int i = 0; i < 8; i++) line_tab[i] = mem[i];
    line_cnt   = ec;
    sp_count   = 4'(cnt);
    dot_en     = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    exp_valid  = 1'b0;
    exp_color  = 4'h0;
    exp_colx   = 9'd0;
    exp_busy   = (ec != 0);
    line_seen  = 1'b0;
    hit_base   = hit_total;
    fetch_cyc  = 0;
    if (ec != 0) begin
      for (int k = 0; k <= ec; k++) begin
        if (ds_in_fetch && k == 0) draw_start = 1'b1;
        @(negedge clk);
        if (busy) fetch_cyc++;
        if (k < ec) chk("ram_addr", 32'(ram_addr), 32'(k));
        tick();
        draw_start = 1'b0;
      end
      exp_busy = 1'b0;
    end
    // The drawer must work from its captured copy, not the live table.
    for (int i = 0; i < 8; i++) mem[i] = $urandom();
  endtask

  task automatic draw_line(input bit m, input int abort_at, input bit gaps);
    bit         v;
    bit         coll;
    logic [3:0] c;
    for (int i = 0; i < 256; i++) begin
      dut_vis[i] = 1'b0;
      dut_col[i] = 4'h0;
    end
    mag        = m;
    draw_start = 1'b1;
    tick();
    draw_start = 1'b0;
    exp_busy   = 1'b1;
    for (int d = 0; d < 256; d++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      if (d == abort_at) return;
      dot_en = 1'b1;
      tick();
      dot_en = 1'b0;
      model_dot(d, m, v, c, coll);
      exp_valid = v;
      exp_color = v ? c : 4'h0;
      if (coll && !line_seen) begin
        line_seen = 1'b1;
        exp_hit   = 1'b1;
        exp_colx  = 9'(d);
      end
      if (d == 255) exp_busy = 1'b0;
      @(negedge clk);
      dut_vis[d] = pix_valid;
      dut_col[d] = pix_color;
    end
    tick();
    exp_valid = 1'b0;
    exp_color = 4'h0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    line_start = 1'b0;
    draw_start = 1'b0;
    dot_en     = 1'b0;
    mag        = 1'b0;
    sp_count   = 4'd0;
    hit_total  = 0;
    hit_base   = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    exp_busy   = 1'b0;
    exp_valid  = 1'b0;
    exp_hit    = 1'b0;
    exp_color  = 4'h0;
    exp_colx   = 9'd0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("busy", 32'(busy), 32'(exp_busy));
          chk("pix_valid", 32'(pix_valid), 32'(exp_valid));
          if (exp_valid) chk("pix_color", 32'(pix_color), 32'(exp_color));
          chk("col_hit", 32'(col_hit), 32'(exp_hit));
          chk("col_x", 32'(col_x), 32'(exp_colx));
          if (col_hit) hit_total++;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_pix_color", 32'(pix_color), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_col_hit", 32'(col_hit), 32'd0);
    chk("rst_col_x", 32'(col_x), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_en = 1'b1;
    repeat (4) tick();

    // Single sprite, pattern edges only.
    mem[0] = mk(10, 16'h8001, 4'd5, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) mem[i] = $urandom();
    do_line_start(1, 1'b0);
    chk("t1_fetch_len", 32'(fetch_cyc), 32'd2);
    draw_line(1'b0, -1, 1'b1);
    chk("t1_vis_count", 32'(vis_count()), 32'd2);
    chk("t1_vis10", 32'(dut_vis[10]), 32'd1);
    chk("t1_col10", 32'(dut_col[10]), 32'd5);
    chk("t1_vis25", 32'(dut_vis[25]), 32'd1);
    chk("t1_col25", 32'(dut_col[25]), 32'd5);

    // CC merge: colour 2 | 8, no collision.
    mem[0] = mk(20, 16'hFFFF, 4'd2, 1'b0, 1'b0);
    mem[1] = mk(20, 16'hFFFF, 4'd8, 1'b1, 1'b0);
    do_line_start(2, 1'b0);
    draw_line(1'b0, -1, 1'b1);
    chk("t2a_col20", 32'(dut_col[20]), 32'hA);
    chk("t2a_vis35", 32'(dut_vis[35]), 32'd1);
    chk("t2a_vis36", 32'(dut_vis[36]), 32'd0);
    chk("t2a_hits", 32'(hit_total - hit_base), 32'd0);

    // Both cc=0, ic=0: base wins and a single collision at dot 20.
    mem[0] = mk(20, 16'hFFFF, 4'd2, 1'b0, 1'b0);
    mem[1] = mk(20, 16'hFFFF, 4'd8, 1'b0, 1'b0);
    do_line_start(2, 1'b0);
    draw_line(1'b0, -1, 1'b1);
    chk("t2b_col20", 32'(dut_col[20]), 32'h2);
    chk("t2b_hits", 32'(hit_total - hit_base), 32'd1);
    chk("t2b_colx", 32'(col_x), 32'd20);

    // ic=1 suppresses the collision.
    mem[0] = mk(20, 16'hFFFF, 4'd2, 1'b0, 1'b0);
    mem[1] = mk(20, 16'hFFFF, 4'd8, 1'b0, 1'b1);
    do_line_start(2, 1'b0);
    draw_line(1'b0, -1, 1'b1);
    chk("t2c_hits", 32'(hit_total - hit_base), 32'd0);

    // Magnified sprite truncated at the right edge.
    mem[0] = mk(250, 16'hC000, 4'd3, 1'b0, 1'b0);
    do_line_start(1, 1'b0);
    draw_line(1'b1, -1, 1'b0);
    chk("t3_vis250", 32'(dut_vis[250]), 32'd1);
    chk("t3_col253", 32'(dut_col[253]), 32'd3);
    chk("t3_vis253", 32'(dut_vis[253]), 32'd1);
    chk("t3_vis254", 32'(dut_vis[254]), 32'd0);
    chk("t3_vis255", 32'(dut_vis[255]), 32'd0);
    chk("t3_idle_busy", 32'(busy), 32'd0);

    // Empty line, then over-range count clamps to 8.
    for (int i = 0; i < 8; i++) mem[i] = rand_entry(30);
    do_line_start(0, 1'b0);
    draw_line(1'b0, -1, 1'b1);
    chk("t4_empty_vis", 32'(vis_count()), 32'd0);
    for (int i = 0; i < 8; i++) mem[i] = rand_entry(60);
    do_line_start(12, 1'b0);
    chk("t4_fetch_len12", 32'(fetch_cyc), 32'd9);
    draw_line(1'b0, -1, 1'b1);

    // Abort at dot 100, DRAW_START during the new fetch must be ignored.
    mem[0] = mk(90, 16'hFFFF, 4'd7, 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) mem[i] = rand_entry(80);
    do_line_start(8, 1'b0);
    draw_line(1'b0, 100, 1'b1);
    for (int i = 0; i < 8; i++) mem[i] = rand_entry(100);
    do_line_start(5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      dot_en = 1'b1;
      tick();
      dot_en = 1'b0;
      tick();
    end
    @(negedge clk);
    chk("t5_ready_busy", 32'(busy), 32'd0);
    draw_line(1'b0, -1, 1'b1);

    // Random lines.
    for (int n = 0; n < 20; n++) begin
      int xb;
      int ab;
      xb = int'($urandom_range(0, 240));
      for (int i = 0; i < 8; i++) mem[i] = rand_entry(xb);
      do_line_start(int'($urandom_range(0, 15)), 1'($urandom()));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : -1;
      draw_line(1'($urandom()), ab, 1'b1);
    end

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
